// File: rtl/accu_mean_pkg.sv
// Shared defaults and FSM state type for the accumulator-mean datapath.
package accu_pkg;

  localparam int unsigned ACCU_SUM_W   = 10;
  localparam int unsigned ACCU_OUT_W   = 8;
  localparam int unsigned ACCU_DIVISOR = 5;
  localparam int unsigned ACCU_DEPTH   = 4;
  // Remainder register holds up to 2*DIVISOR-1 between shift and restore.
  localparam int unsigned ACCU_REM_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_HOLD = 2'd2
  } accu_state_t;

endpackage

// File: rtl/accu_sum_fifo.sv
// Small synchronous FIFO for incoming group sums; full/empty derive from the registered count.
module accu_sum_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/accu_mean.sv
// Buffers group sums and divides each by the constant group size with a serial restoring divider.
module accu_mean
  import accu_pkg::*;
#(
  parameter int unsigned SUM_W   = ACCU_SUM_W,
  parameter int unsigned OUT_W   = ACCU_OUT_W,
  parameter int unsigned DIVISOR = ACCU_DIVISOR,
  parameter int unsigned DEPTH   = ACCU_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [SUM_W-1:0] data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic [2:0]       rem_out,
  output logic             overflow
);

  localparam int unsigned BIT_W = $clog2(SUM_W);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(SUM_W - 1);
  localparam logic [ACCU_REM_W:0] DIV_K    = (ACCU_REM_W + 1)'(DIVISOR);

  accu_state_t           r_state;
  logic [SUM_W-1:0]      r_dvd;
  logic [ACCU_REM_W-1:0] r_rem;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_valid;
  logic [OUT_W-1:0]      r_data;
  logic [2:0]            r_rem_out;
  logic                  r_ovf;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [SUM_W-1:0]      w_head;
  logic [CNT_W-1:0]      w_fifo_count_unused;
  logic [ACCU_REM_W:0]   w_trial;
  logic [ACCU_REM_W:0]   w_diff;
  logic                  w_ge;
  logic [ACCU_REM_W-1:0] w_rem_nxt;
  logic [SUM_W-1:0]      w_quo_nxt;

  accu_sum_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (data_in),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_fifo_count_unused)
  );

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_HOLD: w_pop = ready_in && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push = valid_in && (!w_full || w_pop);

  // Restoring step: the subtraction's borrow bit decides whether to keep the difference.
  assign w_trial   = {r_rem, r_dvd[SUM_W-1]};
  assign w_diff    = w_trial - DIV_K;
  assign w_ge      = !w_diff[ACCU_REM_W];
  assign w_rem_nxt = w_ge ? w_diff[ACCU_REM_W-1:0] : w_trial[ACCU_REM_W-1:0];
  assign w_quo_nxt = {r_dvd[SUM_W-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_bit     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_rem_out <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) r_state <= ST_DIV;
        end
        ST_DIV: begin
          r_dvd <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          if (r_bit == '0) begin
            r_data    <= w_quo_nxt[OUT_W-1:0];
            r_rem_out <= w_rem_nxt[2:0];
            r_valid   <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_bit <= r_bit - 1'b1;
          end
        end
        ST_HOLD: begin
          if (ready_in) begin
            r_valid <= 1'b0;
            r_state <= w_empty ? ST_IDLE : ST_DIV;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Pops only happen in IDLE/HOLD, so this load never collides with a DIV step.
      if (w_pop) begin
        r_dvd <= w_head;
        r_rem <= '0;
        r_bit <= LAST_BIT;
      end
      if (valid_in && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign rem_out   = r_rem_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_accu_mean.sv
// Self-checking bench for accu_mean: fixed vectors, multi-cycle corner sequences and randomized sums.
module tb_accu_mean;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [9:0] data_in;
  logic       ready_in;
  logic       valid_out;
  logic [7:0] data_out;
  logic [2:0] rem_out;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accu_mean #(
    .SUM_W   (10),
    .OUT_W   (8),
    .DIVISOR (5),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .rem_out   (rem_out),
    .overflow  (overflow)
  );

  typedef struct {
    int sum;
    int q;
    int r;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];

  function automatic int model_q(input int s);
    return s / 5;
  endfunction

  function automatic int model_r(input int s);
    return s % 5;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; the sum is sampled on the following rising edge.
  task automatic push(input int s);
    valid_in = 1'b1;
    data_in  = 10'(s);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Waits for valid_out, captures the result, then steps past the handshake edge (ready_in high).
  task automatic get_result(input string name, output int q, output int r, output int t);
    int w = 0;
    while (!valid_out && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!valid_out) begin
      check({name, " timeout"}, 0, 1);
      q = -1;
      r = -1;
      t = cyc;
    end else begin
      q = int'(data_out);
      r = int'(rem_out);
      t = cyc;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q, r, t, t0, t1, w, seen, n, s;

    vecs.push_back('{637, 127, 2});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{1023, 204, 3});
    vecs.push_back('{5, 1, 0});
    vecs.push_back('{4, 0, 4});
    vecs.push_back('{9, 1, 4});
    vecs.push_back('{1022, 204, 2});
    vecs.push_back('{512, 102, 2});

    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset valid_out", int'(valid_out), 0);
    check("reset data_out", int'(data_out), 0);
    check("reset rem_out", int'(rem_out), 0);
    check("reset overflow", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      push(vecs[i].sum);
      t0 = cyc;
      get_result($sformatf("vec%0d", i), q, r, t);
      check($sformatf("vec%0d mean", i), q, vecs[i].q);
      check($sformatf("vec%0d rem", i), r, vecs[i].r);
      check($sformatf("vec%0d latency", i), t - t0, 11);
      check($sformatf("vec%0d single-cycle valid", i), int'(valid_out), 0);
    end

    // Backpressure: result held stable until ready_in returns.
    ready_in = 1'b0;
    push(100);
    w = 0;
    while (!valid_out && w < 60) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 20; k++) begin
      check("bp valid held", int'(valid_out), 1);
      check("bp data stable", int'(data_out), 20);
      check("bp rem stable", int'(rem_out), 0);
      @(negedge clk);
    end
    ready_in = 1'b1;
    @(negedge clk);
    check("bp valid after handshake", int'(valid_out), 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check("bp no duplicate", seen, 0);

    // Back-to-back: second sum goes HOLD -> DIV directly.
    push(333);
    push(47);
    get_result("b2b first", q, r, t0);
    check("b2b first mean", q, model_q(333));
    check("b2b first rem", r, model_r(333));
    get_result("b2b second", q, r, t1);
    check("b2b second mean", q, model_q(47));
    check("b2b second rem", r, model_r(47));
    check("b2b spacing", t1 - t0, 11);

    // Random single transactions with random downstream stall.
    for (int i = 0; i < 20; i++) begin
      s = int'($urandom_range(1023, 0));
      ready_in = 1'b0;
      push(s);
      repeat ($urandom_range(15, 0)) @(negedge clk);
      ready_in = 1'b1;
      get_result("rand", q, r, t);
      check($sformatf("rand %0d mean", s), q, model_q(s));
      check($sformatf("rand %0d rem", s), r, model_r(s));
    end

    // Random bursts of up to DEPTH+1 sums while stalled; all must come out in order.
    for (int b = 0; b < 5; b++) begin
      n = int'($urandom_range(5, 1));
      exp_q.delete();
      ready_in = 1'b0;
      for (int k = 0; k < n; k++) begin
        s = int'($urandom_range(1023, 0));
        exp_q.push_back(s);
        push(s);
      end
      repeat ($urandom_range(20, 0)) @(negedge clk);
      ready_in = 1'b1;
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        get_result("burst", q, r, t);
        check($sformatf("burst %0d mean", s), q, model_q(s));
        check($sformatf("burst %0d rem", s), r, model_r(s));
      end
      check("burst drained", int'(valid_out), 0);
    end
    check("no overflow before overflow test", int'(overflow), 0);

    // Overflow: sixth back-to-back sum is dropped.
    ready_in = 1'b0;
    for (int k = 1; k <= 6; k++) push(10 * k);
    check("overflow set", int'(overflow), 1);
    ready_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      get_result("ovf", q, r, t);
      check($sformatf("ovf result %0d mean", k), q, 2 * k);
      check($sformatf("ovf result %0d rem", k), r, 0);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check("ovf dropped sum absent", seen, 0);
    check("overflow sticky", int'(overflow), 1);

    // Reset mid-DIV with a second sum buffered.
    push(300);
    push(301);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst valid_out", int'(valid_out), 0);
    check("midrst data_out", int'(data_out), 0);
    check("midrst rem_out", int'(rem_out), 0);
    check("midrst overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check("midrst no result", seen, 0);
    push(25);
    t0 = cyc;
    get_result("post-reset", q, r, t);
    check("post-reset mean", q, 5);
    check("post-reset rem", r, 0);
    check("post-reset latency", t - t0, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
